// File: rtl/tt_alu_seq_pkg.sv
// Shared types and constants for the sequenced multi-cycle ALU.
package tt_alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_W   = 5;
    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 2;
    localparam int FLAG_DBZ = 3;
    localparam int FLAG_ILL = 4;

    function automatic logic needs_iter(input logic [3:0] op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/tt_alu_seq_if.sv
// Request/result bundle between the pin wrapper (master) and the ALU core (slave).
interface tt_alu_seq_if
    import tt_alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic              ena;
    logic              start;
    logic [3:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  result_lo;
    logic [WIDTH-1:0]  result_hi;
    logic [FLAG_W-1:0] flags;
    logic              busy;
    logic              done;

    modport master (
        output ena, start, op, a, b,
        input  result_lo, result_hi, flags, busy, done
    );

    modport slave (
        input  ena, start, op, a, b,
        output result_lo, result_hi, flags, busy, done
    );
endinterface

// File: rtl/tt_alu_seq_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide, one bit per step.
// hi/lo present the result of applying one more step to the current state.
module tt_alu_seq_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   rem_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // acc holds the partial product high half / running remainder;
    // sh holds the multiplier (consumed from bit 0) / dividend-then-quotient.
    always_comb begin
        add_w  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        rem_w  = {acc_q, sh_q[WIDTH-1]};
        diff_w = rem_w - {1'b0, m_q};
        if (is_div) begin
            if (!diff_w[WIDTH]) begin
                nxt_hi = diff_w[WIDTH-1:0];
                nxt_lo = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = rem_w[WIDTH-1:0];
                nxt_lo = {sh_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = add_w[WIDTH:1];
            nxt_lo = {add_w[0], sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        sh_d  = sh_q;
        m_d   = m_q;
        if (load) begin
            acc_d = '0;
            sh_d  = a;
            m_d   = b;
        end else if (step) begin
            acc_d = nxt_hi;
            sh_d  = nxt_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sh_q  <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            m_q   <= m_d;
        end
    end

    assign hi = nxt_hi;
    assign lo = nxt_lo;

endmodule

// File: rtl/tt_alu_seq.sv
// Multi-cycle ALU core with start/done handshake, registered results and flags.
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops resolve on the accept edge
//   RUN   | MUL/DIV iterating, one bit per enabled cycle
//   DONE  | done pulse; held while ena is low
module tt_alu_seq
    import tt_alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tt_alu_seq_if.slave   bus
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    alu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d;
    logic [WIDTH-1:0]  res_lo_q, res_lo_d;
    logic [WIDTH-1:0]  res_hi_q, res_hi_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              iter_load;
    logic              iter_step;
    logic [WIDTH-1:0]  iter_hi;
    logic [WIDTH-1:0]  iter_lo;

    logic [SW-1:0]     sh_amt;
    logic [WIDTH:0]    add_w, sub_w, shl_w, shr_w, sra_w;
    logic              b_zero;
    logic [WIDTH-1:0]  sc_lo, sc_hi;
    logic              sc_c, sc_v, sc_ill, sc_dbz;
    logic [FLAG_W-1:0] sc_flags;

    // One extra bit on each shift captures the last bit shifted out (0 when amount is 0).
    always_comb begin
        sh_amt = bus.b[SW-1:0];
        b_zero = (bus.b == '0);
        add_w  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
        shl_w  = {1'b0, bus.a} << sh_amt;
        shr_w  = {bus.a, 1'b0} >> sh_amt;
        sra_w  = $unsigned($signed({bus.a, 1'b0}) >>> sh_amt);
    end

    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
        sc_dbz = 1'b0;
        case (alu_op_e'(bus.op))
            OP_ADD: begin
                sc_lo = add_w[WIDTH-1:0];
                sc_c  = add_w[WIDTH];
                sc_v  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo = sub_w[WIDTH-1:0];
                sc_c  = sub_w[WIDTH];
                sc_v  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: sc_lo = bus.a & bus.b;
            OP_OR:  sc_lo = bus.a | bus.b;
            OP_XOR: sc_lo = bus.a ^ bus.b;
            OP_SHL: begin
                sc_lo = shl_w[WIDTH-1:0];
                sc_c  = shl_w[WIDTH];
            end
            OP_SHR: begin
                sc_lo = shr_w[WIDTH:1];
                sc_c  = shr_w[0];
            end
            OP_SRA: begin
                sc_lo = sra_w[WIDTH:1];
                sc_c  = sra_w[0];
            end
            OP_MUL: ;
            OP_DIV: begin
                if (b_zero) begin
                    sc_lo  = '1;
                    sc_hi  = bus.a;
                    sc_dbz = 1'b1;
                end
            end
            default: sc_ill = 1'b1;
        endcase
        sc_flags           = '0;
        sc_flags[FLAG_Z]   = ({sc_hi, sc_lo} == '0) && !sc_ill;
        sc_flags[FLAG_C]   = sc_c;
        sc_flags[FLAG_V]   = sc_v;
        sc_flags[FLAG_DBZ] = sc_dbz;
        sc_flags[FLAG_ILL] = sc_ill;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        flags_d   = flags_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        div_d = (bus.op == OP_DIV);
                        if (needs_iter(bus.op, b_zero)) begin
                            iter_load = 1'b1;
                            cnt_d     = CW'(WIDTH);
                            state_d   = ST_RUN;
                        end else begin
                            res_lo_d = sc_lo;
                            res_hi_d = sc_hi;
                            flags_d  = sc_flags;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    iter_step = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                    // Terminal count: this step is the last, so capture its output directly.
                    if (cnt_q == CW'(1)) begin
                        res_lo_d         = iter_lo;
                        res_hi_d         = iter_hi;
                        flags_d          = '0;
                        flags_d[FLAG_Z]  = ({iter_hi, iter_lo} == '0);
                        state_d          = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    tt_alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_load),
        .step   (iter_step),
        .is_div (div_q),
        .a      (bus.a),
        .b      (bus.b),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.flags     = flags_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_tt_alu_seq.sv
// Scoreboard bench for tt_alu_seq at WIDTH=8: results checked on each done pulse,
// latency and handshake behaviour checked inline by each scenario task.
module tb_tt_alu_seq;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tt_alu_seq_if #(.WIDTH(W)) bus();

    tt_alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [4:0] flags;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic done_prev = 1'b0;

    // flags = {illegal, dbz, V, C, Z}
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ai, bi, sa, sb, r, sr, n;
        logic c, v, ill, dbz;
        ai = int'(a);
        bi = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = bi % 8;
        e.lo = 8'h00; e.hi = 8'h00;
        c = 1'b0; v = 1'b0; ill = 1'b0; dbz = 1'b0;
        case (op)
            4'd0: begin r = ai + bi; e.lo = r[7:0]; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            4'd1: begin r = ai - bi; e.lo = r[7:0]; c = (ai < bi); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            4'd2: e.lo = a & b;
            4'd3: e.lo = a | b;
            4'd4: e.lo = a ^ b;
            4'd5: begin r = ai << n; e.lo = r[7:0]; c = (n != 0) && r[8]; end
            4'd6: begin r = ai >> n; e.lo = r[7:0]; if (n != 0) begin r = ai >> (n - 1); c = r[0]; end end
            4'd7: begin r = sa >>> n; e.lo = r[7:0]; if (n != 0) begin r = sa >>> (n - 1); c = r[0]; end end
            4'd8: begin r = ai * bi; e.lo = r[7:0]; e.hi = r[15:8]; end
            4'd9: begin
                if (bi == 0) begin e.lo = 8'hFF; e.hi = a; dbz = 1'b1; end
                else begin r = ai / bi; e.lo = r[7:0]; r = ai % bi; e.hi = r[7:0]; end
            end
            default: ill = 1'b1;
        endcase
        e.flags = {ill, dbz, v, c, (e.lo == 8'h00) && (e.hi == 8'h00) && !ill};
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.done && !done_prev) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: done pulse with no pending operation at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                if ({bus.result_hi, bus.result_lo, bus.flags} !== {mon_e.hi, mon_e.lo, mon_e.flags}) begin
                    bad++;
                    $display("FAIL result: hi=%h lo=%h flags=%b, expected hi=%h lo=%h flags=%b",
                             bus.result_hi, bus.result_lo, bus.flags, mon_e.hi, mon_e.lo, mon_e.flags);
                end
            end
        end
        done_prev = bus.done;
    end

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_n);
        sb_q.push_back(model(op, a, b));
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; busy_n = 0;
        for (int n = 1; n <= 100; n++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin lat = n; break; end
            @(posedge clk); #1;
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL op_timeout: op=%0d no done within 100 cycles", op);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.ena = 1'b1; bus.start = 1'b0; bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.result_hi, bus.result_lo, bus.flags, bus.busy, bus.done} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {bus.result_hi, bus.result_lo, bus.flags, bus.busy, bus.done});
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: busy/done=%b, expected 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_single_cycle();
        logic [3:0] ops[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
        logic [7:0] as[10]  = '{8'hF0, 8'h80, 8'hCC, 8'hC0, 8'hFF, 8'h7F, 8'h00, 8'h05, 8'h10, 8'h80};
        logic [7:0] bs[10]  = '{8'h20, 8'h01, 8'hAA, 8'h0C, 8'h0F, 8'h01, 8'h00, 8'h05, 8'h20, 8'h80};
        int lat, busy_n;
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], as[i], bs[i], lat, busy_n);
            total++;
            if (lat !== 1 || busy_n !== 1) begin
                bad++;
                $display("FAIL single_latency[%0d]: latency=%0d busy=%0d, expected 1/1", i, lat, busy_n);
            end
        end
    endtask

    task automatic test_mul_div();
        logic [3:0] ops[8] = '{4'd8, 4'd8, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        logic [7:0] as[8]  = '{8'hFF, 8'h00, 8'h12, 8'd200, 8'd255, 8'd3, 8'd5, 8'd0};
        logic [7:0] bs[8]  = '{8'hFF, 8'h37, 8'h0B, 8'd7, 8'd1, 8'd10, 8'd0, 8'd0};
        int lat, busy_n, exp_lat;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], lat, busy_n);
            exp_lat = (bs[i] == 8'd0 && ops[i] == 4'd9) ? 1 : 9;
            total++;
            if (lat !== exp_lat || busy_n !== exp_lat) begin
                bad++;
                $display("FAIL iter_latency[%0d]: latency=%0d busy=%0d, expected %0d", i, lat, busy_n, exp_lat);
            end
        end
    endtask

    task automatic test_shift_illegal();
        logic [3:0] ops[9] = '{4'd7, 4'd5, 4'd6, 4'd5, 4'd7, 4'd6, 4'd12, 4'd15, 4'd10};
        logic [7:0] as[9]  = '{8'h90, 8'h81, 8'h03, 8'hA5, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h12};
        logic [7:0] bs[9]  = '{8'd3, 8'd1, 8'd1, 8'd8, 8'd7, 8'd7, 8'hFF, 8'h00, 8'h34};
        int lat, busy_n;
        for (int i = 0; i < 9; i++) begin
            do_op(ops[i], as[i], bs[i], lat, busy_n);
            total++;
            if (lat !== 1) begin
                bad++;
                $display("FAIL shift_illegal_latency[%0d]: latency=%0d, expected 1", i, lat);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, idle_busy;
        sb_q.push_back(model(4'd8, 8'h5A, 8'h3C));
        bus.op = 4'd8; bus.a = 8'h5A; bus.b = 8'h3C; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            if (bus.done) begin lat = n; break; end
            if (n == 2 || n == 3 || n == 5) begin
                bus.start = 1'b1; bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h01;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL ignore_start_latency: latency=%0d, expected 9", lat);
        end
        idle_busy = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.busy) idle_busy++;
        end
        total++;
        if (idle_busy !== 0) begin
            bad++;
            $display("FAIL ignore_start_queued: busy cycles after done=%0d, expected 0", idle_busy);
        end
    endtask

    task automatic test_ena_stall();
        int lat, busy_n;
        sb_q.push_back(model(4'd8, 8'hC3, 8'h5D));
        bus.op = 4'd8; bus.a = 8'hC3; bus.b = 8'h5D; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; busy_n = 0;
        for (int n = 1; n <= 100; n++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin lat = n; break; end
            if (n == 4) bus.ena = 1'b0;
            if (n == 7) bus.ena = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (lat !== 12 || busy_n !== 12) begin
            bad++;
            $display("FAIL ena_stall_latency: latency=%0d busy=%0d, expected 12", lat, busy_n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_done_extend();
        int done_n;
        sb_q.push_back(model(4'd0, 8'h01, 8'h01));
        bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h01; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.ena = 1'b0;
        done_n = 0;
        for (int n = 0; n < 6; n++) begin
            if (bus.done) done_n++;
            if (n == 2) bus.ena = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (done_n !== 3) begin
            bad++;
            $display("FAIL done_extend: done high %0d cycles, expected 3", done_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops[3] = '{4'd0, 4'd1, 4'd0};
        logic [7:0] as[3]  = '{8'h11, 8'h00, 8'h40};
        logic [7:0] bs[3]  = '{8'h22, 8'h01, 8'h40};
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.op = ops[i]; bus.a = as[i]; bus.b = bs[i];
            sb_q.push_back(model(ops[i], as[i], bs[i]));
            @(posedge clk); #1;
            total++;
            if ({bus.busy, bus.done} !== 2'b11) begin
                bad++;
                $display("FAIL b2b_done[%0d]: busy/done=%b, expected 11", i, {bus.busy, bus.done});
            end
            @(posedge clk); #1;
            total++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                bad++;
                $display("FAIL b2b_idle[%0d]: busy/done=%b, expected 00", i, {bus.busy, bus.done});
            end
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] a, b;
        int lat, busy_n, exp_lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            do_op(op, a, b, lat, busy_n);
            exp_lat = (op == 4'd8 || (op == 4'd9 && b != 8'd0)) ? 9 : 1;
            total++;
            if (lat !== exp_lat) begin
                bad++;
                $display("FAIL random_latency[%0d]: op=%0d latency=%0d, expected %0d", i, op, lat, exp_lat);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat, busy_n, done_n;
        do_op(4'd0, 8'hF0, 8'h20, lat, busy_n);
        bus.op = 4'd8; bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_busy: busy=%b, expected 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.result_hi, bus.result_lo, bus.flags, bus.busy, bus.done} !== 23'd0) begin
            bad++;
            $display("FAIL midrun_reset_outputs: got %h, expected 0",
                     {bus.result_hi, bus.result_lo, bus.flags, bus.busy, bus.done});
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        done_n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_n++;
        end
        total++;
        if (done_n !== 0) begin
            bad++;
            $display("FAIL aborted_op_done: busy/done seen %0d cycles, expected 0", done_n);
        end
        do_op(4'd0, 8'hF0, 8'h20, lat, busy_n);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL post_reset_add_latency: latency=%0d, expected 1", lat);
        end
        do_op(4'd8, 8'hFF, 8'hFF, lat, busy_n);
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL post_reset_mul_latency: latency=%0d, expected 9", lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul_div();
        test_shift_illegal();
        test_ignore_start();
        test_ena_stall();
        test_done_extend();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tt_alu_seq.md
# tt_alu_seq

Parametrised multi-cycle ALU core, the next generation of the team's TinyTapeout ALU top. It adds a configurable datapath width and a start/done handshake. It also adds iterative multiply and divide alongside the single-cycle logic and arithmetic ops. It sits below the `tt_um_*` pin wrapper, which packs operands and opcode from `ui_in`/`uio_in` and drives results to `uo_out`.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥ 4 and a power of two.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  global enable (TinyTapeout `ena`); when low, all state holds.
- `start`  in  1  request; sampled only in IDLE with `ena`=1.
- `op`  in  4  opcode, latched on accept.
- `a`, `b`  in  WIDTH each  operands, latched on accept.
- `result_lo`  out  WIDTH  primary result: sum, logic result, product low half or quotient.
- `result_hi`  out  WIDTH  product high half or remainder; 0 for other ops.
- `flags`  out  5  {illegal, dbz, V, C, Z}.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR logical, 7 SRA; shift amount = `b[$clog2(WIDTH)-1:0]`.
  - 8 MUL unsigned, 9 DIV unsigned.
  - 10–15 illegal.
- FSM has states IDLE, RUN, DONE.
  - IDLE→DONE on accept of ops 0–7, an illegal op, or DIV with b=0.
  - IDLE→RUN on accept of MUL, or of DIV with b≠0.
  - RUN→DONE after WIDTH iterations.
  - DONE→IDLE unconditionally.
- Accept condition: state IDLE, `ena`=1, `start`=1. The accept edge latches `op`, `a` and `b`.
- MUL is shift-add, one multiplier bit per cycle; the full 2·WIDTH product is produced.
- DIV is restoring, one quotient bit per cycle.
- DIV with b=0: `result_lo` = all ones, `result_hi` = a, dbz=1.
- Illegal op: both results 0 and illegal=1; all other flags 0.
- Flags:
  - Z = (`result_hi`,`result_lo`) all zero.
  - C = carry-out for ADD; borrow (a<b) for SUB; last bit shifted out for SHL/SHR/SRA when amount≠0; 0 otherwise.
  - V = signed overflow for ADD/SUB; 0 otherwise.
- Outputs `result_*` and `flags` are registered. They hold their values from `done` until the next `done`; they do not change during RUN.
- `start` while `busy` is ignored and not queued.
- `ena`=0 freezes the FSM, the iteration counter and the datapath. A pending `done` pulse is extended until the cycle after `ena` returns, then lasts exactly one `ena`=1 cycle.
- Reset, asynchronous at any time including mid-RUN, sets:
  - state to IDLE;
  - `result_lo`, `result_hi`, `flags`, `busy`, `done` all to 0;
  - the iteration counter to 0.
  The aborted operation produces no `done`.

## Timing
- Single-cycle ops, illegal ops and DIV-by-zero: accept at edge k; `done`=1 and results valid in cycle k+1; IDLE again at edge k+2.
- MUL, DIV: accept at edge k; RUN during cycles k+1…k+WIDTH; `done` in cycle k+WIDTH+1. Latency is 9 cycles for WIDTH=8.
- Back-to-back: the earliest next accept is the edge that leaves DONE, i.e. k+2 for single-cycle ops, so throughput is one op per 2 cycles.
- `start` held high continuously is accepted again on each return to IDLE.

## Structure
- Package `tt_alu_seq_pkg` contains:
  - `alu_op_e` (4-bit opcode enum);
  - `alu_state_e` (IDLE/RUN/DONE);
  - flag bit index constants `FLAG_Z`, `FLAG_C`, `FLAG_V`, `FLAG_DBZ`, `FLAG_ILL`.
- Sub-module `tt_alu_seq_iter`, parametrised by WIDTH, holds the shared shift-add/restoring-divide datapath.
  - Inputs: load, step, is_div, a, b.
  - Outputs: hi, lo.
- The single-cycle ops, the FSM and the flag logic stay in `tt_alu_seq`.

## Test plan
- Reset and pass-through (WIDTH=8):
  - Reset mid-run, then ADD a=0xF0, b=0x20 → `done` at +1; `result_lo`=0x10, C=1, V=0, Z=0.
  - SUB a=0x80, b=0x01 → 0x7F, V=1, C=0.
- MUL a=0xFF, b=0xFF → `done` exactly 9 cycles after accept; hi=0xFE, lo=0x01; `busy` high for 9 cycles.
- DIV a=200, b=7 → lo=28, hi=4 after 9 cycles.
- DIV a=5, b=0 → `done` at +1; lo=0xFF, hi=0x05, dbz=1.
- Shifts and illegal op:
  - SRA a=0x90, b=3 → 0xF2, C=0.
  - Opcode 12 → results 0, illegal=1.
  - `start` pulses during a MUL are ignored.
- Disruption:
  - `ena` dropped for 3 cycles mid-MUL → `done` is delayed by exactly 3 cycles with the correct product.
  - `rst_n` asserted during RUN → all outputs 0 immediately and no `done` follows.
